md5_job_controller: RTL and testbench
=====================================

# md5_job_controller

Processor-facing job controller that drives the two-symbol MD5 brute-force engine. It receives the target hash and start string from the processor over a simple register write bus. It sequences the engine's reset, zero-string and clock-enable inputs, then watches the engine's `find_str` and `symbols_done` outputs. It captures the matching string, counts run cycles and exposes status and the result over a registered read bus.

## Interface
Parameters:
- `RST_CYCLES`, 3: cycles `eng_reset`/`eng_reset_zero_string` are held high before a run. The engine pipelines its reset by 2 cycles.
- `CNT_W`, 32: width of the run-cycle counter.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high; clears all state.
- `wr_en` in 1: register write strobe.
- `wr_addr` in 5: 0–15 start-string words; 16–19 hash words a..d; 20 command.
- `wr_data` in 32: write data. For the command register, bit0 = start and bit1 = abort.
- `rd_addr` in 5: 0–15 result words; 16 status; 17 cycle count.
- `rd_data` out 32: registered read data, 1-cycle latency.
- `eng_ce` out 1: engine clock enable.
- `eng_reset` out 1: engine reset.
- `eng_reset_zero_string` out 1: forces the engine to re-hash the start string first.
- `eng_start_str` out 512: start string. Word k maps to bits [32k+31:32k].
- `eng_a_hash`, `eng_b_hash`, `eng_c_hash`, `eng_d_hash` out 32 each: target hash words.
- `eng_find_str` in 1: engine match flag.
- `eng_symbols_done` in 1: engine search-space-exhausted flag.
- `eng_result_str` in 512: engine matching string.
- `irq` out 1: one-cycle pulse when a job ends (found, exhausted or aborted).

## Operation
- FSM states:
  - IDLE: no job. Config writes are accepted.
  - PRIME: assert `eng_reset` and `eng_reset_zero_string` for `RST_CYCLES` cycles. `eng_ce` = 0.
  - RUN: `eng_ce` = 1 and the counter increments.
  - DONE: `eng_ce` = 0, waiting for the next start.
- Start command:
  - Taken in IDLE or DONE, the FSM goes to PRIME. Sticky flags clear, the counter clears and the result words clear.
  - Ignored in PRIME or RUN.
- PRIME→RUN after exactly `RST_CYCLES` cycles.
- In RUN:
  - `eng_find_str` = 1: capture `eng_result_str` into the result words, set `found`, go to DONE.
  - Else if a rising edge of `eng_symbols_done`: set `exhausted`, go to DONE.
  - `find_str` wins when both occur in the same cycle.
  - The `symbols_done` edge detector is cleared on entry to RUN, so a level already high at entry does not count.
- Abort command in PRIME or RUN:
  - Set `aborted`, go to DONE, and assert `eng_reset` for one cycle.
  - Abort in IDLE or DONE has no effect.
  - Start and abort in the same write: abort wins if busy; otherwise start.
- Config writes (addresses 0–19) during PRIME/RUN are ignored. Addresses 21–31 are ignored.
- Status word: bit0 `busy` (PRIME or RUN), bit1 `found`, bit2 `exhausted`, bit3 `aborted`, bits[31:4] = 0.
- Cycle counter: counts RUN cycles and saturates at all-ones.
- Reads of unmapped addresses 18–31 return 0.
- Reset clears every output and register to 0 and puts the FSM in IDLE.

## Timing
- A start write in cycle T puts `eng_reset`/`eng_reset_zero_string` high in cycles T+1…T+`RST_CYCLES`, with `eng_ce` rising at T+`RST_CYCLES`+1.
- `eng_find_str` high in cycle F (RUN) gives:
  - `eng_ce` low from F+1;
  - `found` and the result visible to a read issued at F+1, with data at F+2;
  - `irq` high in F+1 only.
- `eng_symbols_done` rising in cycle E gives:
  - `exhausted` set from E+1;
  - `irq` at E+1.
- An abort write in cycle A gives:
  - `eng_ce` low from A+1;
  - `eng_reset` high in A+1 only;
  - `irq` at A+1.
- `eng_start_str` and the hash outputs are direct register outputs and stable throughout PRIME/RUN.
- `reset` mid-run: in the next cycle `eng_ce` = 0, status = 0 and there is no `irq`.

## Test plan
- Write words 0–15 = 0x41414141 and hash 16–19, then start → `eng_reset` is high for 3 cycles, `eng_ce` rises at start+4, and status reads 0x1.
- In RUN, pulse `eng_find_str` with `eng_result_str` = {16{0x62636465}} → `eng_ce` drops next cycle, one `irq`, status = 0x2, result word 7 = 0x62636465.
- Raise `eng_symbols_done` after 200 RUN cycles → status = 0x4 and counter reads 200.
- Set `find_str` and the `symbols_done` edge in the same cycle → status = 0x2 only.
- Abort at RUN cycle 10:
  - `eng_reset` is a one-cycle pulse, status = 0x8, counter = 10.
  - A following write to word 0 is accepted, and a new start re-primes.
- Assert `reset` mid-RUN → all outputs 0; a start during PRIME and a hash write during RUN are both ignored.

Source files
------------

// File: rtl/md5_job_controller.sv
// md5_job_controller: sequences the two-symbol MD5 brute-force engine.
// The processor loads the start string and target hash, then issues start.
// The controller primes the engine, runs it, and reports found, exhausted
// or aborted together with the matching string and the run-cycle count.
module md5_job_controller #(
    parameter int RST_CYCLES = 3,
    parameter int CNT_W      = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_en,
    input  logic [4:0]   wr_addr,
    input  logic [31:0]  wr_data,
    input  logic [4:0]   rd_addr,
    output logic [31:0]  rd_data,
    output logic         eng_ce,
    output logic         eng_reset,
    output logic         eng_reset_zero_string,
    output logic [511:0] eng_start_str,
    output logic [31:0]  eng_a_hash,
    output logic [31:0]  eng_b_hash,
    output logic [31:0]  eng_c_hash,
    output logic [31:0]  eng_d_hash,
    input  logic         eng_find_str,
    input  logic         eng_symbols_done,
    input  logic [511:0] eng_result_str,
    output logic         irq
);
    typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN, S_DONE} state_t;

    localparam int PW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    state_t             state, state_n;
    logic [PW-1:0]      prime_cnt;
    logic [15:0][31:0]  start_words;
    logic [15:0][31:0]  result_words;
    logic [CNT_W-1:0]   cycle_cnt;
    logic               found, exhausted, aborted;
    logic               sd_prev, abort_rst;
    logic               busy, cmd_wr, do_start, do_abort, sd_rise, prime_last, cfg_wr;
    logic [31:0]        status, cnt32;

    assign busy       = (state == S_PRIME) || (state == S_RUN);
    assign cmd_wr     = wr_en && (wr_addr == 5'd20);
    // Abort only means something while a job is active; otherwise start wins.
    assign do_abort   = cmd_wr && wr_data[1] && busy;
    assign do_start   = cmd_wr && wr_data[0] && !busy;
    assign cfg_wr     = wr_en && !busy;
    // sd_prev tracks the level every cycle, so a level already high when RUN
    // begins is never seen as a rising edge.
    assign sd_rise    = eng_symbols_done && !sd_prev;
    assign prime_last = (prime_cnt == PW'(RST_CYCLES - 1));

    assign eng_ce                = (state == S_RUN);
    assign eng_reset_zero_string = (state == S_PRIME);
    assign eng_reset             = (state == S_PRIME) || abort_rst;
    assign eng_start_str         = start_words;
    assign status                = {28'd0, aborted, exhausted, found, busy};
    assign cnt32                 = 32'(cycle_cnt);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    // Next-state logic; abort takes priority over engine events.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE, S_DONE: if (do_start) state_n = S_PRIME;
            S_PRIME: begin
                if (do_abort)        state_n = S_DONE;
                else if (prime_last) state_n = S_RUN;
            end
            S_RUN: if (do_abort || eng_find_str || sd_rise) state_n = S_DONE;
            default: state_n = S_IDLE;
        endcase
    end

    // Job datapath: config registers, flags, result capture, counter, irq.
    always_ff @(posedge clk) begin
        if (reset) begin
            prime_cnt    <= '0;
            start_words  <= '0;
            result_words <= '0;
            cycle_cnt    <= '0;
            found        <= 1'b0;
            exhausted    <= 1'b0;
            aborted      <= 1'b0;
            sd_prev      <= 1'b0;
            abort_rst    <= 1'b0;
            irq          <= 1'b0;
            eng_a_hash   <= '0;
            eng_b_hash   <= '0;
            eng_c_hash   <= '0;
            eng_d_hash   <= '0;
        end else begin
            irq       <= 1'b0;
            abort_rst <= 1'b0;
            sd_prev   <= eng_symbols_done;
            if (state == S_PRIME) prime_cnt <= prime_cnt + 1'b1;
            if (cfg_wr && !wr_addr[4]) start_words[wr_addr[3:0]] <= wr_data;
            if (cfg_wr) begin
                case (wr_addr)
                    5'd16:   eng_a_hash <= wr_data;
                    5'd17:   eng_b_hash <= wr_data;
                    5'd18:   eng_c_hash <= wr_data;
                    5'd19:   eng_d_hash <= wr_data;
                    default: ;
                endcase
            end
            if (do_start) begin
                prime_cnt    <= '0;
                result_words <= '0;
                cycle_cnt    <= '0;
                found        <= 1'b0;
                exhausted    <= 1'b0;
                aborted      <= 1'b0;
            end
            if (state == S_RUN && cycle_cnt != '1) cycle_cnt <= cycle_cnt + 1'b1;
            if (do_abort) begin
                aborted   <= 1'b1;
                abort_rst <= 1'b1;
                irq       <= 1'b1;
            end else if (state == S_RUN) begin
                if (eng_find_str) begin
                    found        <= 1'b1;
                    result_words <= eng_result_str;
                    irq          <= 1'b1;
                end else if (sd_rise) begin
                    exhausted <= 1'b1;
                    irq       <= 1'b1;
                end
            end
        end
    end

    // Registered read mux, one-cycle latency.
    always_ff @(posedge clk) begin
        if (reset)                rd_data <= '0;
        else if (!rd_addr[4])     rd_data <= result_words[rd_addr[3:0]];
        else if (rd_addr == 5'd16) rd_data <= status;
        else if (rd_addr == 5'd17) rd_data <= cnt32;
        else                      rd_data <= '0;
    end
endmodule

// File: tb/tb_md5_job_controller.sv
// Self-checking bench for md5_job_controller: table-driven config writes,
// a read scoreboard, and hand-written sequences for the job corner cases.
module tb_md5_job_controller;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         wr_en = 1'b0;
    logic [4:0]   wr_addr = '0;
    logic [31:0]  wr_data = '0;
    logic [4:0]   rd_addr = '0;
    logic [31:0]  rd_data;
    logic         eng_ce, eng_reset, eng_reset_zero_string;
    logic [511:0] eng_start_str;
    logic [31:0]  eng_a_hash, eng_b_hash, eng_c_hash, eng_d_hash;
    logic         eng_find_str = 1'b0;
    logic         eng_symbols_done = 1'b0;
    logic [511:0] eng_result_str = '0;
    logic         irq;

    int tests = 0;
    int fails = 0;

    logic [15:0][31:0] model_str;
    logic [3:0][31:0]  model_hash;
    logic [31:0]       exp_q[$];
    string             nm_q[$];

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wvec_t;
    wvec_t vt[8];
    logic [4:0] unmapped[3];

    md5_job_controller #(.RST_CYCLES(3), .CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .eng_ce(eng_ce), .eng_reset(eng_reset),
        .eng_reset_zero_string(eng_reset_zero_string),
        .eng_start_str(eng_start_str),
        .eng_a_hash(eng_a_hash), .eng_b_hash(eng_b_hash),
        .eng_c_hash(eng_c_hash), .eng_d_hash(eng_d_hash),
        .eng_find_str(eng_find_str), .eng_symbols_done(eng_symbols_done),
        .eng_result_str(eng_result_str), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    // Expected read data is queued when the read is issued and compared when
    // the registered data appears one cycle later.
    task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string nm);
        rd_addr = a;
        exp_q.push_back(exp);
        nm_q.push_back(nm);
        tick();
        chk(nm_q.pop_front(), rd_data, exp_q.pop_front());
    endtask

    // Start write, then land in the first RUN cycle.
    task automatic start_job();
        wr(5'd20, 32'h1);
        repeat (2) tick();
        tick();
    endtask

    function automatic logic [127:0] hash_out();
        return {eng_d_hash, eng_c_hash, eng_b_hash, eng_a_hash};
    endfunction

    initial begin
        vt[0] = '{5'd0,  32'h11111111};
        vt[1] = '{5'd7,  32'h77777777};
        vt[2] = '{5'd15, 32'hffff0000};
        vt[3] = '{5'd16, 32'h01234567};
        vt[4] = '{5'd17, 32'h89abcdef};
        vt[5] = '{5'd18, 32'hfedcba98};
        vt[6] = '{5'd19, 32'h76543210};
        vt[7] = '{5'd25, 32'hdeadbeef};
        unmapped[0] = 5'd18; unmapped[1] = 5'd24; unmapped[2] = 5'd31;
        model_str = '0;
        model_hash = '0;

        // Reset state
        tick(); tick();
        reset = 1'b0;
        chk("rst_ce", eng_ce, 0);
        chk("rst_eng_reset", eng_reset, 0);
        chk("rst_zero_str", eng_reset_zero_string, 0);
        chk("rst_irq", irq, 0);
        chk("rst_str", eng_start_str, 0);
        rd(5'd16, 32'h0, "rst_status");
        rd(5'd17, 32'h0, "rst_cnt");

        // Config table in IDLE
        foreach (vt[i]) begin
            wr(vt[i].addr, vt[i].data);
            if (vt[i].addr < 5'd16) model_str[vt[i].addr[3:0]] = vt[i].data;
            else if (vt[i].addr < 5'd20) model_hash[vt[i].addr - 5'd16] = vt[i].data;
            chk($sformatf("cfg_str_%0d", i), eng_start_str, model_str);
            chk($sformatf("cfg_hash_%0d", i), hash_out(), model_hash);
        end
        foreach (unmapped[i]) rd(unmapped[i], 32'h0, $sformatf("unmapped_%0d", unmapped[i]));
        for (int k = 0; k < 16; k++) begin
            wr(5'(k), 32'h41414141);
            model_str[k] = 32'h41414141;
        end
        chk("cfg_str_all41", eng_start_str, model_str);

        // Start: reset high for 3 cycles, ce rises at start+4
        wr(5'd20, 32'h1);
        for (int i = 1; i <= 3; i++) begin
            chk($sformatf("prime_rst_%0d", i), eng_reset, 1);
            chk($sformatf("prime_zs_%0d", i), eng_reset_zero_string, 1);
            chk($sformatf("prime_ce_%0d", i), eng_ce, 0);
            if (i < 3) tick();
        end
        tick();
        chk("run_ce", eng_ce, 1);
        chk("run_rst", eng_reset, 0);
        rd(5'd16, 32'h1, "run_status");
        wr(5'd16, 32'h0);
        chk("run_hash_ignored", hash_out(), model_hash);
        chk("run_str_stable", eng_start_str, model_str);

        // Find
        eng_result_str = {16{32'h62636465}};
        eng_find_str = 1'b1;
        tick();
        eng_find_str = 1'b0;
        chk("find_ce", eng_ce, 0);
        chk("find_irq", irq, 1);
        tick();
        chk("find_irq_once", irq, 0);
        rd(5'd16, 32'h2, "find_status");
        rd(5'd7, 32'h62636465, "find_word7");

        // Exhausted after 200 RUN cycles; result cleared by start
        start_job();
        repeat (199) tick();
        eng_symbols_done = 1'b1;
        tick();
        chk("exh_irq", irq, 1);
        chk("exh_ce", eng_ce, 0);
        rd(5'd16, 32'h4, "exh_status");
        rd(5'd17, 32'd200, "exh_cnt");
        rd(5'd7, 32'h0, "exh_word7_cleared");

        // Level high at RUN entry is not an edge; then find + edge together
        start_job();
        repeat (5) tick();
        chk("lvl_still_run", eng_ce, 1);
        eng_symbols_done = 1'b0;
        tick();
        eng_result_str = {16{32'h13572468}};
        eng_find_str = 1'b1;
        eng_symbols_done = 1'b1;
        tick();
        eng_find_str = 1'b0;
        eng_symbols_done = 1'b0;
        chk("both_irq", irq, 1);
        rd(5'd16, 32'h2, "both_status");
        rd(5'd0, 32'h13572468, "both_word0");

        // Abort at RUN cycle 10
        start_job();
        repeat (9) tick();
        wr(5'd20, 32'h2);
        chk("abort_rst", eng_reset, 1);
        chk("abort_ce", eng_ce, 0);
        chk("abort_irq", irq, 1);
        tick();
        chk("abort_rst_once", eng_reset, 0);
        rd(5'd16, 32'h8, "abort_status");
        rd(5'd17, 32'd10, "abort_cnt");
        wr(5'd0, 32'h12345678);
        model_str[0] = 32'h12345678;
        chk("abort_cfg_wr", eng_start_str, model_str);
        wr(5'd20, 32'h1);
        chk("restart_prime", eng_reset_zero_string, 1);
        wr(5'd20, 32'h3);
        rd(5'd16, 32'h8, "busy_abort_wins");
        wr(5'd20, 32'h3);
        chk("idle_start_wins", eng_reset_zero_string, 1);
        repeat (3) tick();
        chk("pre_reset_ce", eng_ce, 1);

        // Synchronous reset mid-RUN
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_str = '0;
        model_hash = '0;
        chk("mid_rst_ce", eng_ce, 0);
        chk("mid_rst_eng_reset", eng_reset, 0);
        chk("mid_rst_irq", irq, 0);
        chk("mid_rst_str", eng_start_str, 0);
        chk("mid_rst_hash", hash_out(), 0);
        rd(5'd16, 32'h0, "mid_rst_status");

        // Start during PRIME ignored: PRIME length stays 3
        wr(5'd20, 32'h1);
        wr(5'd20, 32'h1);
        tick();
        chk("reprime_ce_low", eng_ce, 0);
        tick();
        chk("reprime_ce_high", eng_ce, 1);
        wr(5'd16, 32'hdeadbeef);
        chk("run_hash_a_ignored", eng_a_hash, 0);
        wr(5'd20, 32'h2);
        rd(5'd16, 32'h8, "final_status");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
